// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared definitions for the quick_spi client arbiter
//
// Holds the arbiter FSM state encoding and the requester index width helper
// used by spi_arbiter and rr_arbiter.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin requester selection
//
// Ports:
//   req_i   - request vector, one bit per client
//   ptr_i   - index of the client granted last; search starts one above it
//   grant_o - one-hot grant (all zero when no request)
//   idx_o   - binary index of the granted client (zero when no request)
module rr_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int IW             = idx_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic [IW-1:0]             ptr_i,
  output logic [NUM_REQUESTERS-1:0] grant_o,
  output logic [IW-1:0]             idx_o
);

  logic found;
  int   cand;

  // Walk ptr+1, ptr+2, ... ptr+N (mod N); the last candidate is ptr itself,
  // so a lone requester that was just served can still win again.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      cand = (int'(ptr_i) + i) % NUM_REQUESTERS;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one quick_spi master between clients
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   req_i                  - level request per client
//   num_data_i, wdata_i    - per-client bit count and write data (packed, client 0 in LSBs)
//   done_o, error_o        - one-hot completion / timeout pulse for the served client
//   rdata_o                - read data of the last completed transfer
//   busy_o                 - a transaction is in flight
//   spi_request_o, spi_num_data_o, spi_data_o - to quick_spi request_i/num_data_i/data_i
//   spi_data_i, spi_data_valid_i, spi_cs_n_i   - from quick_spi data_o/data_valid_o/cs_n_o
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 4,
  parameter int MAX_DATA_LENGTH = 16,
  parameter int NUM_DEVICES     = 1,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [NUM_REQUESTERS-1:0]                             req_i,
  input  logic [NUM_REQUESTERS*$clog2(MAX_DATA_LENGTH)-1:0]     num_data_i,
  input  logic [NUM_REQUESTERS*MAX_DATA_LENGTH*NUM_DEVICES-1:0] wdata_i,
  output logic [NUM_REQUESTERS-1:0]                             done_o,
  output logic [NUM_REQUESTERS-1:0]                             error_o,
  output logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0]                rdata_o,
  output logic                                                  busy_o,
  output logic                                                  spi_request_o,
  output logic [$clog2(MAX_DATA_LENGTH)-1:0]                    spi_num_data_o,
  output logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0]                spi_data_o,
  input  logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0]                spi_data_i,
  input  logic                                                  spi_data_valid_i,
  input  logic                                                  spi_cs_n_i
);

  localparam int IW = idx_width(NUM_REQUESTERS);
  localparam int NW = $clog2(MAX_DATA_LENGTH);
  localparam int DW = MAX_DATA_LENGTH * NUM_DEVICES;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             ptr_q;
  logic [NUM_REQUESTERS-1:0] gnt_oh_q;
  logic [CW-1:0]             cnt_q;

  logic [NUM_REQUESTERS-1:0] rr_grant;
  logic [IW-1:0]             rr_idx;
  logic                      any_req;
  logic                      grant_now;
  logic                      timeout;

  logic                      spi_request_d;
  logic                      busy_d;
  logic [NUM_REQUESTERS-1:0] done_d;
  logic [NUM_REQUESTERS-1:0] error_d;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IW            (IW)
  ) u_rr (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .grant_o(rr_grant),
    .idx_o  (rr_idx)
  );

  assign any_req   = |req_i;
  assign grant_now = (state_q == ST_IDLE) && any_req;
  assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Forward progress (cs_n low, data valid) wins over a timeout
  // landing on the same cycle, since the transfer is then still within bounds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (any_req) state_d = ST_REQUEST;
      ST_REQUEST: begin
        if (!spi_cs_n_i)  state_d = ST_ACTIVE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (spi_data_valid_i) state_d = ST_COMPLETE;
        else if (timeout)     state_d = ST_IDLE;
      end
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  // A REQUEST/ACTIVE -> IDLE transition can only be a timeout.
  always_comb begin
    spi_request_d = (state_d == ST_REQUEST);
    busy_d        = (state_d != ST_IDLE);
    done_d        = '0;
    error_d       = '0;
    if (state_q == ST_ACTIVE && state_d == ST_COMPLETE) begin
      done_d = gnt_oh_q;
    end
    if ((state_q == ST_REQUEST || state_q == ST_ACTIVE) && state_d == ST_IDLE) begin
      error_d = gnt_oh_q;
    end
  end

  // Output, grant and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spi_request_o  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= '0;
      error_o        <= '0;
      rdata_o        <= '0;
      spi_num_data_o <= '0;
      spi_data_o     <= '0;
      cnt_q          <= '0;
      ptr_q          <= IW'(NUM_REQUESTERS - 1);
      gnt_oh_q       <= '0;
    end else begin
      spi_request_o <= spi_request_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      error_o       <= error_d;

      if (grant_now) begin
        // Latch the client's command so later input changes cannot disturb it.
        ptr_q          <= rr_idx;
        gnt_oh_q       <= rr_grant;
        spi_num_data_o <= num_data_i[32'(rr_idx)*NW +: NW];
        spi_data_o     <= wdata_i[32'(rr_idx)*DW +: DW];
        cnt_q          <= '0;
      end else if (state_q == ST_REQUEST || state_q == ST_ACTIVE) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == ST_ACTIVE && spi_data_valid_i) begin
        rdata_o <= spi_data_i;
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] num_data;
  logic [63:0] wdata;
  logic [15:0] spi_rdata;
  logic        spi_valid;
  logic        spi_cs_n;

  logic [3:0]  done, error;
  logic [15:0] rdata;
  logic        busy, spi_req;
  logic [3:0]  spi_num;
  logic [15:0] spi_data;

  logic [3:0]  done_t, error_t;
  logic [15:0] rdata_t;
  logic        busy_t, spi_req_t;
  logic [3:0]  spi_num_t;
  logic [15:0] spi_data_t;

  int checks   = 0;
  int failures = 0;

  spi_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .num_data_i      (num_data),
    .wdata_i         (wdata),
    .done_o          (done),
    .error_o         (error),
    .rdata_o         (rdata),
    .busy_o          (busy),
    .spi_request_o   (spi_req),
    .spi_num_data_o  (spi_num),
    .spi_data_o      (spi_data),
    .spi_data_i      (spi_rdata),
    .spi_data_valid_i(spi_valid),
    .spi_cs_n_i      (spi_cs_n)
  );

  spi_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .num_data_i      (num_data),
    .wdata_i         (wdata),
    .done_o          (done_t),
    .error_o         (error_t),
    .rdata_o         (rdata_t),
    .busy_o          (busy_t),
    .spi_request_o   (spi_req_t),
    .spi_num_data_o  (spi_num_t),
    .spi_data_o      (spi_data_t),
    .spi_data_i      (spi_rdata),
    .spi_data_valid_i(spi_valid),
    .spi_cs_n_i      (spi_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = 4'b0000;
    num_data  = '0;
    wdata     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    spi_rdata = '0;
    spi_valid = 1'b0;
    spi_cs_n  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    checks++; if (spi_req !== 1'b0) begin failures++; $display("FAIL rst_spi_req got=%b exp=0", spi_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 4'b0 || error !== 4'b0) begin failures++; $display("FAIL rst_pulses done=%b error=%b exp=0", done, error); end
    checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
    checks++; if (spi_data !== 16'h0 || spi_num !== 4'h0) begin failures++; $display("FAIL rst_spi_cmd data=%h num=%h exp=0", spi_data, spi_num); end
    @(negedge clk);
    checks++; if (spi_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_hold req=%b busy=%b exp=0", spi_req, busy); end
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req             = 4'b0010;
    num_data[7:4]   = 4'd8;
    wdata[31:16]    = 16'hA5C3;
    @(negedge clk);
    checks++; if (spi_req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", spi_req); end
    checks++; if (spi_data !== 16'hA5C3) begin failures++; $display("FAIL single_data got=%h exp=a5c3", spi_data); end
    checks++; if (spi_num !== 4'd8) begin failures++; $display("FAIL single_num got=%0d exp=8", spi_num); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req          = 4'b0000;
    wdata[31:16] = 16'hFFFF;
    num_data     = 16'hFFFF;
    spi_cs_n     = 1'b0;
    @(negedge clk);
    checks++; if (spi_req !== 1'b0) begin failures++; $display("FAIL single_req_drop got=%b exp=0", spi_req); end
    checks++; if (spi_data !== 16'hA5C3 || spi_num !== 4'd8) begin failures++; $display("FAIL single_latched data=%h num=%0d exp=a5c3/8", spi_data, spi_num); end
    spi_valid = 1'b1;
    spi_rdata = 16'h1234;
    @(negedge clk);
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL single_done got=%b exp=0010", done); end
    checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL single_rdata got=%h exp=1234", rdata); end
    checks++; if (error !== 4'b0) begin failures++; $display("FAIL single_error got=%b exp=0000", error); end
    spi_valid = 1'b0;
    spi_rdata = 16'h0000;
    @(negedge clk);
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0000", done); end
    checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL single_rdata_hold got=%h exp=1234", rdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    spi_cs_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_idx [5];
    logic [15:0] exp_data;
    logic [3:0]  exp_done;
    exp_idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    do_reset();
    @(negedge clk);
    req      = 4'b1111;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_data = 16'h1111 * (16'(exp_idx[i]) + 16'd1);
      exp_done = 4'b0001 << exp_idx[i];
      @(negedge clk);
      checks++; if (spi_req !== 1'b1 || spi_data !== exp_data) begin failures++; $display("FAIL rr_grant_%0d req=%b data=%h exp=1/%h", i, spi_req, spi_data, exp_data); end
      @(negedge clk);
      spi_valid = 1'b1;
      spi_rdata = 16'h00A0 + 16'(i);
      @(negedge clk);
      checks++; if (done !== exp_done || rdata !== 16'h00A0 + 16'(i)) begin failures++; $display("FAIL rr_done_%0d done=%b rdata=%h exp=%b/%h", i, done, rdata, exp_done, 16'h00A0 + 16'(i)); end
      spi_valid = 1'b0;
      @(negedge clk);
    end
    req      = 4'b0000;
    spi_cs_n = 1'b1;
  endtask

  task automatic test_accept_delay();
    do_reset();
    @(negedge clk);
    req          = 4'b0100;
    wdata[47:32] = 16'hC0DE;
    spi_cs_n     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = 4'b0000;
      checks++; if (spi_req !== 1'b1) begin failures++; $display("FAIL accept_req_%0d got=%b exp=1", i, spi_req); end
      checks++; if (done !== 4'b0 || rdata !== 16'h0) begin failures++; $display("FAIL accept_ignore_%0d done=%b rdata=%h exp=0/0000", i, done, rdata); end
      if (i == 5) begin spi_valid = 1'b1; spi_rdata = 16'hBEEF; end
      if (i == 6) begin spi_valid = 1'b0; spi_rdata = 16'h0000; end
    end
    spi_cs_n = 1'b0;
    @(negedge clk);
    checks++; if (spi_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL accept_drop req=%b busy=%b exp=0/1", spi_req, busy); end
    spi_valid = 1'b1;
    spi_rdata = 16'h5A5A;
    @(negedge clk);
    checks++; if (done !== 4'b0100 || rdata !== 16'h5A5A) begin failures++; $display("FAIL accept_done done=%b rdata=%h exp=0100/5a5a", done, rdata); end
    spi_valid = 1'b0;
    spi_cs_n  = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    req      = 4'b0001;
    spi_cs_n = 1'b1;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (spi_req_t !== 1'b1) begin failures++; $display("FAIL to_req got=%b exp=1", spi_req_t); end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      checks++; if (error_t !== 4'b0 || spi_req_t !== 1'b1) begin failures++; $display("FAIL to_early_%0d error=%b req=%b exp=0000/1", k, error_t, spi_req_t); end
    end
    @(negedge clk);
    checks++; if (error_t !== 4'b0001) begin failures++; $display("FAIL to_error got=%b exp=0001", error_t); end
    checks++; if (spi_req_t !== 1'b0 || busy_t !== 1'b0 || done_t !== 4'b0) begin failures++; $display("FAIL to_state req=%b busy=%b done=%b exp=0/0/0000", spi_req_t, busy_t, done_t); end
    @(negedge clk);
    checks++; if (error_t !== 4'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0000", error_t); end
  endtask

  task automatic test_reset_active();
    do_reset();
    @(negedge clk);
    req      = 4'b0001;
    spi_cs_n = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || spi_req !== 1'b0 || spi_data !== 16'h1111) begin failures++; $display("FAIL ra_active busy=%b req=%b data=%h exp=1/0/1111", busy, spi_req, spi_data); end
    spi_valid = 1'b1;
    spi_rdata = 16'h9999;
    rst_n     = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || spi_req !== 1'b0) begin failures++; $display("FAIL ra_async busy=%b req=%b exp=0/0", busy, spi_req); end
    checks++; if (spi_data !== 16'h0 || spi_num !== 4'h0 || rdata !== 16'h0) begin failures++; $display("FAIL ra_async_data data=%h num=%h rdata=%h exp=0", spi_data, spi_num, rdata); end
    @(negedge clk);
    checks++; if (done !== 4'b0 || error !== 4'b0) begin failures++; $display("FAIL ra_no_pulse done=%b error=%b exp=0", done, error); end
    rst_n     = 1'b1;
    spi_valid = 1'b0;
    spi_cs_n  = 1'b1;
    @(negedge clk);
    checks++; if (done !== 4'b0 || error !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL ra_after done=%b error=%b busy=%b exp=0", done, error, busy); end
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (spi_req !== 1'b1 || spi_data !== 16'h4444) begin failures++; $display("FAIL ra_regrant req=%b data=%h exp=1/4444", spi_req, spi_data); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    num_data  = '0;
    wdata     = '0;
    spi_rdata = '0;
    spi_valid = 1'b0;
    spi_cs_n  = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_accept_delay();
    test_timeout();
    test_reset_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of client ports sharing one quick_spi master.
REQ-002 SHALL have parameter MAX_DATA_LENGTH, default 16, bits per device per transfer, matching quick_spi.
REQ-003 SHALL have parameter NUM_DEVICES, default 1, parallel SPI devices, matching quick_spi.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, max clk_i cycles from grant to spi_data_valid_i.
REQ-005 SHALL have ports clk_i (in, 1, system clock) and rst_ni (in, 1, reset). One clock; reset is asynchronous and active-low.
REQ-006 SHALL have req_i (in, NUM_REQUESTERS, level request per client).
REQ-007 SHALL have num_data_i (in, NUM_REQUESTERS*$clog2(MAX_DATA_LENGTH), per-client bit count) and wdata_i (in, NUM_REQUESTERS*MAX_DATA_LENGTH*NUM_DEVICES, per-client write data).
REQ-008 SHALL have done_o (out, NUM_REQUESTERS, one-hot completion pulse), error_o (out, NUM_REQUESTERS, one-hot timeout pulse), rdata_o (out, MAX_DATA_LENGTH*NUM_DEVICES, read data for the client pulsed) and busy_o (out, 1, transaction in flight).
REQ-009 SHALL have spi_request_o (out, 1), spi_num_data_o (out, $clog2(MAX_DATA_LENGTH)) and spi_data_o (out, MAX_DATA_LENGTH*NUM_DEVICES), driving quick_spi request_i, num_data_i and data_i.
REQ-010 SHALL have spi_data_i (in, MAX_DATA_LENGTH*NUM_DEVICES), spi_data_valid_i (in, 1) and spi_cs_n_i (in, 1), fed from quick_spi data_o, data_valid_o and cs_n_o.

Function
REQ-011 SHALL implement FSM states IDLE, REQUEST, ACTIVE, COMPLETE; all outputs registered.
REQ-012 IDLE: if any req_i is high, SHALL grant one client round-robin, latch that client's num_data_i/wdata_i into spi_num_data_o/spi_data_o, and move to REQUEST; spi_request_o is high from the next cycle.
REQ-013 Round-robin SHALL search from (last granted index + 1) mod NUM_REQUESTERS upward with wrap; the pointer updates only on grant; after reset the pointer equals NUM_REQUESTERS-1, so client 0 wins first.
REQ-014 REQUEST: SHALL hold spi_request_o high until spi_cs_n_i is sampled low, then drop it and enter ACTIVE; this tolerates quick_spi still being in its RESET state.
REQ-015 ACTIVE: on spi_data_valid_i high SHALL capture spi_data_i into rdata_o and enter COMPLETE; spi_request_o SHALL be low throughout so quick_spi does not chain a second transfer.
REQ-016 COMPLETE: SHALL pulse done_o[grant] for exactly one cycle with rdata_o valid, then return to IDLE; the earliest re-grant is the following cycle.
REQ-017 Latency from req_i high in IDLE to spi_request_o high SHALL be 1 cycle; from spi_data_valid_i to done_o SHALL be 1 cycle.
REQ-018 A timeout counter SHALL clear on grant and increment in REQUEST/ACTIVE. On reaching TIMEOUT_CYCLES-1 it SHALL drop spi_request_o, pulse error_o[grant] for one cycle, and return to IDLE.
REQ-019 spi_data_valid_i seen outside ACTIVE SHALL be ignored.
REQ-020 Changes to req_i, num_data_i or wdata_i after grant SHALL NOT affect the transaction in flight; a req_i still high after done_o counts as a new request.
REQ-021 busy_o SHALL be high in REQUEST, ACTIVE and COMPLETE.
REQ-022 rdata_o SHALL hold its last captured value between transactions.

Reset
REQ-023 While rst_ni is low, the block SHALL asynchronously force: state IDLE, spi_request_o 0, done_o 0, error_o 0, busy_o 0, rdata_o 0, spi_num_data_o 0, spi_data_o 0, counter 0, pointer NUM_REQUESTERS-1.
REQ-024 Reset asserted mid-transaction SHALL abort it without any done_o or error_o pulse.

Structure
REQ-025 State encodings and the index width ($clog2(NUM_REQUESTERS), min 1) SHALL live in the shared spi package.
REQ-026 Round-robin selection SHALL be one sub-module, rr_arbiter (req vector + pointer in, one-hot grant + index out, combinational); the FSM and counter stay in spi_arbiter.

Verification
REQ-027 Single request: req_i=4'b0010, num_data=8, wdata=16'hA5C3 -> spi_request_o high 1 cycle later, spi_data_o=16'hA5C3; spi_data_valid_i with 16'h1234 -> done_o=4'b0010, rdata_o=16'h1234 for one cycle.
REQ-028 Round-robin: req_i=4'b1111 held -> grant order 0,1,2,3,0.
REQ-029 Acceptance delay: spi_cs_n_i held high 20 cycles -> spi_request_o stays high 20 cycles, drops the cycle after cs_n is seen low.
REQ-030 Timeout: TIMEOUT_CYCLES=16, no spi_data_valid_i -> error_o[grant] pulses at cycle 16 after grant, no done_o, state IDLE.
REQ-031 Reset in ACTIVE: rst_ni low mid-transfer -> all outputs zero immediately, no pulse; after release req_i=4'b1000 grants client 3.
